// File: rtl/gray_timer_pkg.sv
// Shared definitions for the gray timer: FSM state encoding and the
// binary/gray conversion helpers used by the controller and the counter.
// Helpers work on 32-bit values; callers zero-extend and truncate with casts.
package gray_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter.sv
// N-bit gray-code counter with synchronous load and enable.
// Ports:
//   clk        in  clock, posedge
//   load       in  load load_value (gray) on next edge; has priority
//   load_value in  gray value to load
//   enable     in  advance one gray step on next edge (wraps 2^N-1 -> 0)
//   q          out current gray count
// No reset: contents are undefined until the first load.
module gray_counter
  import gray_timer_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         enable,
  output logic [N-1:0] q
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;
  logic [N-1:0] bin_next;

  always_comb begin
    bin_next = N'(gray2bin(32'(q_q))) + N'(1);
    q_d      = q_q;
    if (load) begin
      q_d = load_value;
    end else if (enable) begin
      q_d = N'(bin2gray(32'(bin_next)));
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/gray_timer_ctrl.sv
// Programmable one-shot / periodic timer built around a gray_counter.
// The controller loads the start value, enables counting, detects the
// terminal count directly on the gray output and pulses done.
// Optional macro GRAY_TIMER_PRESCALE_EN adds a psc input and a down-counter
// prescaler so RUN only acts once every psc+1 cycles.
// Ports:
//   clk          in  clock, posedge
//   rstn         in  asynchronous reset, active-low
//   start        in  start request, sampled in IDLE only
//   stop         in  abort request, honoured in LOAD/RUN
//   periodic     in  auto-reload at terminal count (latched on start)
//   start_value  in  binary first count (latched on start)
//   end_value    in  binary terminal count (latched on start)
//   psc          in  prescale divisor minus one (GRAY_TIMER_PRESCALE_EN only)
//   busy         out high in LOAD/RUN
//   done         out one-cycle pulse at terminal count
//   cnt_valid    out q_gray defined (set by the first load)
//   q_gray       out gray count from the counter
//
// state | meaning
// IDLE  | waiting for start; counter holds
// LOAD  | one cycle loading gray(start_value) into the counter
// RUN   | counting toward end_value; done at terminal count
module gray_timer_ctrl
  import gray_timer_pkg::*;
#(
  parameter int N     = 4,
  parameter int PSC_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [N-1:0]     start_value,
  input  logic [N-1:0]     end_value,
`ifdef GRAY_TIMER_PRESCALE_EN
  input  logic [PSC_W-1:0] psc,
`endif
  output logic             busy,
  output logic             done,
  output logic             cnt_valid,
  output logic [N-1:0]     q_gray
);

  if (N < 2 || PSC_W < 1) begin : g_bad_param
    $error("gray_timer_ctrl: requires N >= 2 and PSC_W >= 1");
  end

  state_t       state_q, state_d;
  logic         periodic_q, periodic_d;
  logic [N-1:0] start_gray_q, start_gray_d;
  logic [N-1:0] end_gray_q, end_gray_d;
  logic         cnt_valid_q, cnt_valid_d;

  logic         cnt_load;
  logic         cnt_enable;
  logic         term;
  logic         tick;

`ifdef GRAY_TIMER_PRESCALE_EN
  logic [PSC_W-1:0] psc_l_q, psc_l_d;
  logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;

  assign tick = (psc_cnt_q == '0);

  always_comb begin
    psc_l_d   = psc_l_q;
    psc_cnt_d = psc_cnt_q;
    if (state_q == ST_IDLE && start) begin
      psc_l_d = psc;
    end
    if (state_q == ST_LOAD) begin
      psc_cnt_d = psc_l_q;
    end else if (state_q == ST_RUN) begin
      psc_cnt_d = tick ? psc_l_q : psc_cnt_q - PSC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      psc_l_q   <= '0;
      psc_cnt_q <= '0;
    end else begin
      psc_l_q   <= psc_l_d;
      psc_cnt_q <= psc_cnt_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Compare in the gray domain; end_value was converted once at start.
  assign term = (q_gray == end_gray_q);

  always_comb begin
    state_d      = state_q;
    periodic_d   = periodic_q;
    start_gray_d = start_gray_q;
    end_gray_d   = end_gray_q;
    cnt_valid_d  = cnt_valid_q;
    cnt_load     = 1'b0;
    cnt_enable   = 1'b0;
    done         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          periodic_d   = periodic;
          start_gray_d = N'(bin2gray(32'(start_value)));
          end_gray_d   = N'(bin2gray(32'(end_value)));
          state_d      = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          cnt_load    = 1'b1;
          cnt_valid_d = 1'b1;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        // stop beats a simultaneous terminal count
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (term) begin
            done = 1'b1;
            if (periodic_q) begin
              cnt_load = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_enable = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      periodic_q   <= 1'b0;
      start_gray_q <= '0;
      end_gray_q   <= '0;
      cnt_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      periodic_q   <= periodic_d;
      start_gray_q <= start_gray_d;
      end_gray_q   <= end_gray_d;
      cnt_valid_q  <= cnt_valid_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign cnt_valid = cnt_valid_q;

  gray_counter #(.N(N)) u_counter (
    .clk        (clk),
    .load       (cnt_load),
    .load_value (start_gray_q),
    .enable     (cnt_enable),
    .q          (q_gray)
  );

endmodule

// File: tb/tb_gray_timer_ctrl.sv
module tb_gray_timer_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       stop;
  logic       periodic;
  logic [3:0] start_value;
  logic [3:0] end_value;
`ifdef GRAY_TIMER_PRESCALE_EN
  logic [7:0] psc;
`endif
  logic       busy;
  logic       done;
  logic       cnt_valid;
  logic [3:0] q_gray;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gray_timer_ctrl #(.N(4), .PSC_W(8)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .stop        (stop),
    .periodic    (periodic),
    .start_value (start_value),
    .end_value   (end_value),
`ifdef GRAY_TIMER_PRESCALE_EN
    .psc         (psc),
`endif
    .busy        (busy),
    .done        (done),
    .cnt_valid   (cnt_valid),
    .q_gray      (q_gray)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic [3:0] sv, input logic [3:0] ev, input logic per);
    start       = 1'b1;
    start_value = sv;
    end_value   = ev;
    periodic    = per;
  endtask

  task automatic clear_start();
    start       = 1'b0;
    start_value = 4'hF;
    end_value   = 4'hF;
    periodic    = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    clear_start();
    stop = 1'b0;
`ifdef GRAY_TIMER_PRESCALE_EN
    psc = 8'd0;
`endif
    step();
    step();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++;
    if (cnt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_valid: got %b expected 0", cnt_valid); end
    rstn = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_oneshot();
    logic [3:0] exp_q [4] = '{4'h2, 4'h6, 4'h7, 4'h5};
    set_start(4'd3, 4'd6, 1'b0);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL oneshot_c0_busy: got %b expected 0", busy); end
    step();
    clear_start();
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL oneshot_load: busy=%b done=%b expected busy=1 done=0", busy, done);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (q_gray !== exp_q[i] || done !== (i == 3) || busy !== 1'b1 || cnt_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL oneshot_run[%0d]: q=%h done=%b busy=%b valid=%b expected q=%h done=%b busy=1 valid=1",
                 i, q_gray, done, busy, cnt_valid, exp_q[i], (i == 3));
      end
    end
    step();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || q_gray !== 4'h5) begin
      n_fail++; $display("FAIL oneshot_end: busy=%b done=%b q=%h expected 0 0 5", busy, done, q_gray);
    end
  endtask

  task automatic test_periodic_wrap();
    logic [3:0] exp_q [4] = '{4'h9, 4'h8, 4'h0, 4'h1};
    set_start(4'd14, 4'd1, 1'b1);
    step();
    clear_start();
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (q_gray !== exp_q[i % 4] || done !== ((i % 4) == 3)) begin
        n_fail++;
        $display("FAIL periodic_run[%0d]: q=%h done=%b expected q=%h done=%b",
                 i, q_gray, done, exp_q[i % 4], ((i % 4) == 3));
      end
    end
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || q_gray !== 4'h9) begin
      n_fail++; $display("FAIL periodic_stop: busy=%b q=%h expected busy=0 q=9", busy, q_gray);
    end
  endtask

  task automatic test_equal_values();
    set_start(4'd5, 4'd5, 1'b1);
    step();
    clear_start();
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (q_gray !== 4'h7 || done !== 1'b1) begin
        n_fail++; $display("FAIL equal_run[%0d]: q=%h done=%b expected q=7 done=1", i, q_gray, done);
      end
    end
    stop = 1'b1;
    #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL equal_stop_cycle: done=%b busy=%b expected done=0 busy=1", done, busy);
    end
    step();
    stop = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || q_gray !== 4'h7 || done !== 1'b0) begin
      n_fail++; $display("FAIL equal_after_stop: busy=%b q=%h done=%b expected 0 7 0", busy, q_gray, done);
    end
  endtask

  task automatic test_stop_on_term();
    set_start(4'd0, 4'd2, 1'b0);
    step();
    clear_start();
    step();
    step();
    step();
    n_checks++;
    if (q_gray !== 4'h3 || done !== 1'b1) begin
      n_fail++; $display("FAIL stopterm_pre: q=%h done=%b expected q=3 done=1", q_gray, done);
    end
    stop = 1'b1;
    #1;
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL stopterm_done: got %b expected 0", done); end
    step();
    stop = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || q_gray !== 4'h3) begin
      n_fail++; $display("FAIL stopterm_idle: busy=%b q=%h expected busy=0 q=3", busy, q_gray);
    end
  endtask

  task automatic test_start_while_busy();
    set_start(4'd1, 4'd3, 1'b0);
    step();
    set_start(4'd9, 4'd9, 1'b1);
    step();
    n_checks++;
    if (q_gray !== 4'h1 || done !== 1'b0) begin
      n_fail++; $display("FAIL busystart_c2: q=%h done=%b expected q=1 done=0", q_gray, done);
    end
    step();
    clear_start();
    n_checks++;
    if (q_gray !== 4'h3 || done !== 1'b0) begin
      n_fail++; $display("FAIL busystart_c3: q=%h done=%b expected q=3 done=0", q_gray, done);
    end
    step();
    n_checks++;
    if (q_gray !== 4'h2 || done !== 1'b1) begin
      n_fail++; $display("FAIL busystart_c4: q=%h done=%b expected q=2 done=1", q_gray, done);
    end
    step();
    n_checks++;
    if (busy !== 1'b0 || q_gray !== 4'h2) begin
      n_fail++; $display("FAIL busystart_end: busy=%b q=%h expected busy=0 q=2", busy, q_gray);
    end
  endtask

  task automatic test_reset_mid_run();
    set_start(4'd2, 4'd10, 1'b1);
    step();
    clear_start();
    step();
    step();
    rstn = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cnt_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset: busy=%b done=%b valid=%b expected 0 0 0", busy, done, cnt_valid);
    end
    step();
    rstn = 1'b1;
    step();
    set_start(4'd0, 4'd2, 1'b0);
    step();
    clear_start();
    n_checks++;
    if (cnt_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL restart_load: valid=%b busy=%b expected valid=0 busy=1", cnt_valid, busy);
    end
    for (int c = 2; c <= 4; c++) begin
      step();
      n_checks++;
      if (done !== (c == 4) || cnt_valid !== 1'b1) begin
        n_fail++; $display("FAIL restart_c%0d: done=%b valid=%b expected done=%b valid=1", c, done, cnt_valid, (c == 4));
      end
    end
    n_checks++;
    if (q_gray !== 4'h3) begin n_fail++; $display("FAIL restart_q: got %h expected 3", q_gray); end
    step();
  endtask

`ifdef GRAY_TIMER_PRESCALE_EN
  task automatic test_prescale();
    logic [3:0] exp_q [6] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1};
    psc = 8'd2;
    set_start(4'd0, 4'd1, 1'b0);
    step();
    clear_start();
    psc = 8'd0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (q_gray !== exp_q[i] || done !== (i == 5)) begin
        n_fail++; $display("FAIL prescale[%0d]: q=%h done=%b expected q=%h done=%b", i, q_gray, done, exp_q[i], (i == 5));
      end
    end
    step();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL prescale_end: busy=%b expected 0", busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_oneshot();
    test_periodic_wrap();
    test_equal_values();
    test_stop_on_term();
    test_start_while_busy();
    test_reset_mid_run();
`ifdef GRAY_TIMER_PRESCALE_EN
    test_prescale();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
